// File: rtl/int_div_iter.sv
// Iterative restoring radix-2^DIVCOPIES integer divider for DIV/DIVU/REM/REMU and the RV64 W forms.
// Optional macro IDIV_FASTSPECIAL_EN: a zero divisor or zero dividend skips BUSY and goes straight to DONE.
module int_div_iter #(
  parameter int XLEN      = 64,
  parameter int DIVCOPIES = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallM,
  input  logic            FlushE,
  input  logic            IntDivE,
  input  logic [2:0]      Funct3E,
  input  logic            W64E,
  input  logic [XLEN-1:0] ForwardedSrcAE,
  input  logic [XLEN-1:0] ForwardedSrcBE,
  output logic            DivBusyE,
  output logic            DivDoneE,
  output logic [XLEN-1:0] DivResultE
);
  localparam int N   = XLEN / DIVCOPIES;
  localparam int NW  = 32 / DIVCOPIES;
  localparam int CW  = $clog2(N) + 1;
  localparam int WSH = XLEN - 32;
  localparam logic [CW-1:0]   LAST_X  = CW'(N - 1);
  localparam logic [CW-1:0]   LAST_W  = CW'(NW - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;

  logic [CW-1:0]   count;
  logic [XLEN-1:0] rem_q, quo_q, divisor_q, dividend_q, result_r;
  logic            remop_q, w_q, neg_q_r, neg_r_r, div0_q, ovf_q, done_r;

  // Handshake: a start is accepted when IntDivE is high in IDLE without FlushE; DivBusyE holds
  // the pipeline from that cycle until the result appears with DivDoneE, which is held until
  // the instruction leaves E (~StallM).
  logic div_start;
  assign div_start  = IntDivE & (state == IDLE) & ~FlushE;
  assign DivBusyE   = ~reset & (div_start | (state == BUSY));
  assign DivDoneE   = done_r;
  assign DivResultE = result_r;

  logic unused_bits;
  assign unused_bits = Funct3E[2];

  logic            w_op, sa, sb, ovf;
  logic [XLEN-1:0] a_ext, b_ext, abs_a, abs_b, quo_init;
  always_comb begin
    w_op = (XLEN == 64) && W64E;
    a_ext = ForwardedSrcAE;
    b_ext = ForwardedSrcBE;
    if (w_op) begin
      a_ext = Funct3E[0] ? XLEN'(ForwardedSrcAE[31:0]) : XLEN'($signed(ForwardedSrcAE[31:0]));
      b_ext = Funct3E[0] ? XLEN'(ForwardedSrcBE[31:0]) : XLEN'($signed(ForwardedSrcBE[31:0]));
    end
    sa = ~Funct3E[0] & a_ext[XLEN-1];
    sb = ~Funct3E[0] & b_ext[XLEN-1];
    abs_a = sa ? -a_ext : a_ext;
    abs_b = sb ? -b_ext : b_ext;
    // W dividends sit in the top 32 bits so 32 steps leave the quotient in the low half
    quo_init = w_op ? (abs_a << WSH) : abs_a;
    ovf = ~Funct3E[0] && (b_ext == '1) &&
          (w_op ? (a_ext[31:0] == 32'h8000_0000) : (a_ext == MIN_NEG));
  end

  logic [XLEN:0]   trial;
  logic [XLEN-1:0] r_nx, q_nx;
  always_comb begin
    r_nx  = rem_q;
    q_nx  = quo_q;
    trial = '0;
    for (int i = 0; i < DIVCOPIES; i++) begin
      trial = {r_nx, q_nx[XLEN-1]};
      if (trial >= {1'b0, divisor_q}) begin
        trial = trial - {1'b0, divisor_q};
        q_nx  = {q_nx[XLEN-2:0], 1'b1};
      end else begin
        q_nx  = {q_nx[XLEN-2:0], 1'b0};
      end
      r_nx = trial[XLEN-1:0];
    end
  end

  logic [XLEN-1:0] uq, sq, sr, sel, res;
  always_comb begin
    uq = w_q ? XLEN'(q_nx[31:0]) : q_nx;
    sq = neg_q_r ? -uq : uq;
    sr = neg_r_r ? -r_nx : r_nx;
    if (div0_q) begin
      sq = '1;
      sr = dividend_q;
    end else if (ovf_q) begin
      sq = dividend_q;
      sr = '0;
    end
    sel = remop_q ? sr : sq;
    res = w_q ? XLEN'($signed(sel[31:0])) : sel;
  end

`ifdef IDIV_FASTSPECIAL_EN
  logic            fast_hit;
  logic [XLEN-1:0] fast_sel, fast_res;
  always_comb begin
    fast_hit = (b_ext == '0) || (a_ext == '0);
    fast_sel = (b_ext == '0) ? (Funct3E[1] ? a_ext : '1) : '0;
    fast_res = w_op ? XLEN'($signed(fast_sel[31:0])) : fast_sel;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      done_r     <= 1'b0;
      result_r   <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      divisor_q  <= '0;
      dividend_q <= '0;
      remop_q    <= 1'b0;
      w_q        <= 1'b0;
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
      div0_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else if (FlushE) begin
      state    <= IDLE;
      count    <= '0;
      done_r   <= 1'b0;
      result_r <= '0;
    end else begin
      case (state)
        IDLE: if (IntDivE) begin
          dividend_q <= a_ext;
          divisor_q  <= abs_b;
          quo_q      <= quo_init;
          rem_q      <= '0;
          remop_q    <= Funct3E[1];
          w_q        <= w_op;
          neg_q_r    <= sa ^ sb;
          neg_r_r    <= sa;
          div0_q     <= (b_ext == '0);
          ovf_q      <= ovf;
          count      <= '0;
`ifdef IDIV_FASTSPECIAL_EN
          if (fast_hit) begin
            state    <= DONE;
            done_r   <= 1'b1;
            result_r <= fast_res;
          end else begin
            state <= BUSY;
          end
`else
          state <= BUSY;
`endif
        end
        BUSY: begin
          rem_q <= r_nx;
          quo_q <= q_nx;
          count <= count + 1'b1;
          if (count == (w_q ? LAST_W : LAST_X)) begin
            state    <= DONE;
            done_r   <= 1'b1;
            result_r <= res;
          end
        end
        DONE: if (!StallM) begin
          state    <= IDLE;
          done_r   <= 1'b0;
          result_r <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
